// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer
// Converts captured N, M and C divide values into high/low/bypass/odd
// parameters, writes them one by one into the PLL reconfiguration core with a
// busy handshake, fires the reconfigure strobe and then supervises PLL lock
// with a timeout and a bounded number of areset/relock retries.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   trigger                 start request, only honoured in IDLE
//   pll_n, pll_m, pll_c     divide values (C0 in the LSBs of pll_c)
//   busy                    high whenever the sequencer is not IDLE
//   done                    one-cycle pulse after a stable lock
//   error                   sticky failure flag, cleared by the next trigger
//   attempts                lock retries consumed in the last run
//   stable_reconfig         pll_locked while idle and error-free
//   rcfg_*                  reconfiguration core interface
//   pll_areset, pll_locked  PLL reset request and lock indicator
module pll_reconfig_sequencer #(
    parameter int NUM_C         = 1,
    parameter int DIV_W         = 8,
    parameter int DATA_W        = 9,
    parameter int LOCK_STABLE   = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int BUSY_TIMEOUT  = 1023,
    parameter int MAX_RETRIES   = 2,
    parameter int ARESET_CYCLES = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic [DIV_W-1:0]       pll_m,
    input  logic [DIV_W-1:0]       pll_n,
    input  logic [NUM_C*DIV_W-1:0] pll_c,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             attempts,
    output logic                   stable_reconfig,
    output logic                   rcfg_reset,
    output logic [3:0]             rcfg_counter_type,
    output logic [2:0]             rcfg_counter_param,
    output logic [DATA_W-1:0]      rcfg_data_in,
    output logic                   rcfg_write_param,
    output logic                   rcfg_reconfig,
    input  logic                   rcfg_busy,
    output logic                   pll_areset,
    input  logic                   pll_locked
);

    localparam int NUM_WR   = 4 * (NUM_C + 2);
    localparam int WIDX_W   = $clog2(NUM_WR);
    localparam int BUSY_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam int STABLE_W = $clog2(LOCK_STABLE + 1);
    localparam int LOCKTO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int ARES_W   = $clog2(ARESET_CYCLES + 1);

    localparam logic [WIDX_W-1:0]   WR_LAST     = WIDX_W'(NUM_WR - 1);
    localparam logic [BUSY_W-1:0]   BUSY_LAST   = BUSY_W'(BUSY_TIMEOUT - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE - 1);
    localparam logic [LOCKTO_W-1:0] LOCKTO_LAST = LOCKTO_W'(LOCK_TIMEOUT - 1);
    localparam logic [ARES_W-1:0]   ARES_LAST   = ARES_W'(ARESET_CYCLES - 1);
    localparam logic [1:0]          RETRY_LIMIT = 2'(MAX_RETRIES);

    typedef enum logic [3:0] {
        INIT, IDLE, WR_SETUP, WR_PULSE, WR_GAP, WR_WAIT,
        RC_PULSE, RC_GAP, RC_WAIT, LOCK_WAIT, ARESET
    } state_t;

    state_t state, state_next;

    logic                         init_pulse;
    logic [(NUM_C+2)*DIV_W-1:0]   shadow;
    logic [WIDX_W-1:0]            widx;
    logic [BUSY_W-1:0]            busy_cnt;
    logic [STABLE_W-1:0]          stable_cnt;
    logic [LOCKTO_W-1:0]          lock_cnt;
    logic [ARES_W-1:0]            ares_cnt;

    logic capture, set_error, set_done, retry, next_write;
    logic in_write, busy_wait;

    int               ctr_sel;
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] div_high;
    logic [DIV_W-1:0] param_val;
    logic             div_small;

    // State register; any synchronous reset abandons the run and re-enters INIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the control strobes derived from the current state.
    always_comb begin
        state_next       = state;
        capture          = 1'b0;
        set_error        = 1'b0;
        set_done         = 1'b0;
        retry            = 1'b0;
        next_write       = 1'b0;
        busy             = (state != IDLE);
        rcfg_reset       = (state == INIT) && init_pulse;
        rcfg_write_param = (state == WR_PULSE);
        rcfg_reconfig    = (state == RC_PULSE);
        pll_areset       = (state == ARESET);
        stable_reconfig  = pll_locked && (state == IDLE) && !error;

        case (state)
            INIT:      if (init_pulse) state_next = IDLE;
            IDLE: begin
                if (trigger) begin
                    capture    = 1'b1;
                    state_next = WR_SETUP;
                end
            end
            WR_SETUP:  state_next = WR_PULSE;
            WR_PULSE:  state_next = WR_GAP;
            WR_GAP:    state_next = WR_WAIT;
            WR_WAIT: begin
                if (!rcfg_busy) begin
                    if (widx == WR_LAST) begin
                        state_next = RC_PULSE;
                    end else begin
                        next_write = 1'b1;
                        state_next = WR_SETUP;
                    end
                end else if (busy_cnt == BUSY_LAST) begin
                    set_error  = 1'b1;
                    state_next = IDLE;
                end
            end
            RC_PULSE:  state_next = RC_GAP;
            RC_GAP:    state_next = RC_WAIT;
            RC_WAIT: begin
                if (!rcfg_busy) begin
                    state_next = LOCK_WAIT;
                end else if (busy_cnt == BUSY_LAST) begin
                    set_error  = 1'b1;
                    state_next = IDLE;
                end
            end
            LOCK_WAIT: begin
                // A stable lock takes priority over a coincident timeout.
                if (pll_locked && (stable_cnt == STABLE_LAST)) begin
                    set_done   = 1'b1;
                    state_next = IDLE;
                end else if (lock_cnt == LOCKTO_LAST) begin
                    if (attempts < RETRY_LIMIT) begin
                        retry      = 1'b1;
                        state_next = ARESET;
                    end else begin
                        set_error  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            ARESET:    if (ares_cnt == ARES_LAST) state_next = LOCK_WAIT;
            default:   state_next = INIT;
        endcase
    end

    assign in_write  = (state == WR_SETUP) || (state == WR_PULSE) ||
                       (state == WR_GAP)   || (state == WR_WAIT);
    assign busy_wait = (state == WR_WAIT) || (state == RC_WAIT);

    // Datapath: shadow capture, status flags and the supervision counters.
    // Each counter is held at zero outside the state that uses it, so entry
    // into that state always starts a fresh count.
    always_ff @(posedge clock) begin
        if (reset) begin
            init_pulse <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            attempts   <= 2'd0;
            shadow     <= '0;
            widx       <= '0;
            busy_cnt   <= '0;
            stable_cnt <= '0;
            lock_cnt   <= '0;
            ares_cnt   <= '0;
        end else begin
            init_pulse <= (state == INIT);
            done       <= set_done;
            if (capture) begin
                shadow   <= {pll_c, pll_m, pll_n};
                error    <= 1'b0;
                attempts <= 2'd0;
                widx     <= '0;
            end
            if (set_error)  error    <= 1'b1;
            if (retry)      attempts <= attempts + 1'b1;
            if (next_write) widx     <= widx + 1'b1;

            busy_cnt   <= (busy_wait && rcfg_busy) ? busy_cnt + 1'b1 : '0;
            stable_cnt <= ((state == LOCK_WAIT) && pll_locked) ? stable_cnt + 1'b1 : '0;
            lock_cnt   <= (state == LOCK_WAIT) ? lock_cnt + 1'b1 : '0;
            ares_cnt   <= (state == ARESET) ? ares_cnt + 1'b1 : '0;
        end
    end

    // Write bus decode: the upper index bits pick the counter (N, M, C0..),
    // the low two bits pick high/low/bypass/odd. Values of 0 and 1 map to
    // bypass with high=low=1.
    always_comb begin
        ctr_sel = int'(widx >> 2);
        cur_div = '0;
        for (int i = 0; i < NUM_C + 2; i++) begin
            if (ctr_sel == i) cur_div = shadow[i*DIV_W +: DIV_W];
        end
        div_small = (cur_div <= DIV_W'(1));
        div_high  = {1'b0, cur_div[DIV_W-1:1]} + {{(DIV_W-1){1'b0}}, cur_div[0]};

        case (widx[1:0])
            2'd0:    param_val = div_small ? DIV_W'(1) : div_high;
            2'd1:    param_val = div_small ? DIV_W'(1) : {1'b0, cur_div[DIV_W-1:1]};
            2'd2:    param_val = div_small ? DIV_W'(1) : '0;
            default: param_val = div_small ? '0 : {{(DIV_W-1){1'b0}}, cur_div[0]};
        endcase

        rcfg_counter_type  = 4'd0;
        rcfg_counter_param = 3'd0;
        rcfg_data_in       = '0;
        if (in_write) begin
            rcfg_counter_type = 4'((ctr_sel < 2) ? ctr_sel : ctr_sel + 2);
            case (widx[1:0])
                2'd0:    rcfg_counter_param = 3'd0;
                2'd1:    rcfg_counter_param = 3'd1;
                2'd2:    rcfg_counter_param = 3'd4;
                default: rcfg_counter_param = 3'd5;
            endcase
            rcfg_data_in = DATA_W'(param_val);
        end
    end

endmodule
